ads_frame_rx: RTL and testbench



---
 rtl/ads_frame_rx_pkg.sv | 21 ++
 rtl/ads_frame_rx_if.sv | 28 ++
 rtl/ads_frame_rx_sync_edge_det.sv | 26 ++
 rtl/ads_frame_rx.sv | 136 +++++++++++++
 tb/tb_ads_frame_rx.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/ads_frame_rx_pkg.sv
// Shared definitions for the ADS1299-style readout front-end and the ANC stage downstream.
// Frame geometry, header sync pattern and receiver state encoding.
package ads_frame_rx_pkg;

  localparam int W1_DEF     = 24;
  localparam int NCH_DEF    = 8;
  localparam int FRAME_BITS = (NCH_DEF + 1) * W1_DEF;

  localparam logic [3:0] STATUS_SYNC = 4'b1100;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic header_ok(input logic [3:0] hdr);
    return hdr == STATUS_SYNC;
  endfunction

endpackage

// File: rtl/ads_frame_rx_if.sv
// Serial ADC pins plus the decoded sample bus of the frame receiver.
// The master side is the receiver; the slave side is the ADC / sample consumer.
interface ads_frame_rx_if
  import ads_frame_rx_pkg::*;
#(
  parameter int W1 = W1_DEF
);
  logic          drdy_n;
  logic          dout;
  logic          sclk;
  logic          cs_n;
  logic [W1-1:0] Sn0;
  logic [W1-1:0] Rn0;
  logic [W1-1:0] status;
  logic          valid;
  logic          frame_err;
  logic          ovr;

  modport master (
    input  drdy_n, dout,
    output sclk, cs_n, Sn0, Rn0, status, valid, frame_err, ovr
  );

  modport slave (
    output drdy_n, dout,
    input  sclk, cs_n, Sn0, Rn0, status, valid, frame_err, ovr
  );
endinterface

// File: rtl/ads_frame_rx_sync_edge_det.sv
// Two-flop synchronizer for an asynchronous active-low strobe, plus a registered
// one-cycle pulse on its synchronized falling edge.
module sync_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic fall
);
  logic sync1_reg, sync2_reg, sync3_reg;
  logic fall_reg;

  // The chain keeps tracking the pin during reset so a line held low across
  // reset release is not mistaken for a fresh edge.
  always_ff @(posedge clk) begin
    sync1_reg <= async_in;
    sync2_reg <= sync1_reg;
    sync3_reg <= sync2_reg;
    if (reset) begin
      fall_reg <= 1'b0;
    end else begin
      fall_reg <= sync3_reg & ~sync2_reg;
    end
  end

  assign fall = fall_reg;
endmodule

// File: rtl/ads_frame_rx.sv
// Clocks one status+channels frame out of the ADC per DRDY and presents the
// selected signal/reference channels with a one-cycle valid strobe.
module ads_frame_rx
  import ads_frame_rx_pkg::*;
#(
  parameter int W1     = W1_DEF,
  parameter int NCH    = NCH_DEF,
  parameter int CLKDIV = 4,
  parameter int SN_CH  = 1,
  parameter int RN_CH  = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           en,
  ads_frame_rx_if.master bus
);
  localparam int FB    = (NCH + 1) * W1;
  localparam int CNT_W = $clog2(FB);
  localparam int DIV_W = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam int SN_HI = FB - 1 - W1 * SN_CH;
  localparam int RN_HI = FB - 1 - W1 * RN_CH;

  state_t           state_reg, state_next;
  logic             drdy_fall;
  logic [DIV_W-1:0] div_cnt_reg;
  logic [CNT_W-1:0] bit_cnt_reg;
  logic [FB-1:0]    shift_reg;
  logic             sclk_reg, cs_n_reg, valid_reg, frame_err_reg, ovr_reg;
  logic [W1-1:0]    sn_reg, rn_reg, status_reg;
  logic             start, shifting, sample_edge, commit, tick, last_bit;

  sync_edge_det u_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (bus.drdy_n),
    .fall     (drdy_fall)
  );

  assign tick     = div_cnt_reg == DIV_W'(CLKDIV - 1);
  assign last_bit = bit_cnt_reg == CNT_W'(FB - 1);

  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (sample_edge && last_bit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A data bit is taken on the clk edge that brings sclk back low.
  always_comb begin
    start       = 1'b0;
    shifting    = 1'b0;
    sample_edge = 1'b0;
    commit      = 1'b0;
    case (state_reg)
      IDLE:  start = drdy_fall & en;
      SHIFT: begin
        shifting    = 1'b1;
        sample_edge = tick & sclk_reg;
      end
      DONE:  commit = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_reg   <= '0;
      bit_cnt_reg   <= '0;
      shift_reg     <= '0;
      sclk_reg      <= 1'b0;
      cs_n_reg      <= 1'b1;
      valid_reg     <= 1'b0;
      frame_err_reg <= 1'b0;
      ovr_reg       <= 1'b0;
      sn_reg        <= '0;
      rn_reg        <= '0;
      status_reg    <= '0;
    end else begin
      valid_reg     <= 1'b0;
      frame_err_reg <= 1'b0;
      if (drdy_fall && state_reg != IDLE) ovr_reg <= 1'b1;

      if (start) begin
        cs_n_reg    <= 1'b0;
        sclk_reg    <= 1'b0;
        div_cnt_reg <= '0;
        bit_cnt_reg <= '0;
      end

      if (shifting) begin
        if (tick) begin
          div_cnt_reg <= '0;
          sclk_reg    <= ~sclk_reg;
        end else begin
          div_cnt_reg <= div_cnt_reg + 1'b1;
        end
      end

      if (sample_edge) begin
        shift_reg   <= {shift_reg[FB-2:0], bus.dout};
        bit_cnt_reg <= bit_cnt_reg + 1'b1;
      end

      // Raw slices only; channels are already two's complement on the wire.
      if (commit) begin
        cs_n_reg <= 1'b1;
        if (header_ok(shift_reg[FB-1 -: 4])) begin
          valid_reg  <= 1'b1;
          status_reg <= shift_reg[FB-1 -: W1];
          sn_reg     <= shift_reg[SN_HI -: W1];
          rn_reg     <= shift_reg[RN_HI -: W1];
        end else begin
          frame_err_reg <= 1'b1;
        end
      end
    end
  end

  assign bus.sclk      = sclk_reg;
  assign bus.cs_n      = cs_n_reg;
  assign bus.Sn0       = sn_reg;
  assign bus.Rn0       = rn_reg;
  assign bus.status    = status_reg;
  assign bus.valid     = valid_reg;
  assign bus.frame_err = frame_err_reg;
  assign bus.ovr       = ovr_reg;
endmodule

// File: tb/tb_ads_frame_rx.sv
// Directed bench for ads_frame_rx: table of frames plus hand-written corner sequences,
// with a behavioural ADC that shifts the frame out MSB first on sclk rising edges.
module tb_ads_frame_rx;
  import ads_frame_rx_pkg::*;

  localparam int CLKDIV = 4;
  localparam int FB     = 216;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic en    = 1'b1;

  ads_frame_rx_if #(.W1(24)) bus_if ();

  ads_frame_rx #(
    .W1(24), .NCH(8), .CLKDIV(CLKDIV), .SN_CH(2), .RN_CH(8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] hdr;
    logic [23:0] c2;
    logic [23:0] c8;
    logic        exp_valid;
    logic [23:0] exp_sn;
    logic [23:0] exp_rn;
    logic [23:0] exp_st;
  } vec_t;

  vec_t vecs [7];
  int n_cmp = 0;
  int n_bad = 0;

  logic [FB-1:0] cur_frame = '0;
  int bit_idx     = 0;
  int rises       = 0;
  int total_rises = 0;

  // ADC model: next bit appears on each sclk rise, first bit is the frame MSB.
  always @(posedge bus_if.sclk) begin
    if (bit_idx < FB) bus_if.dout = cur_frame[FB-1-bit_idx];
    bit_idx     = bit_idx + 1;
    rises       = rises + 1;
    total_rises = total_rises + 1;
  end

  always @(negedge bus_if.cs_n) begin
    bit_idx = 0;
    rises   = 0;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [FB-1:0] build_frame(input vec_t v);
    logic [FB-1:0] f;
    logic [23:0]   ch;
    f = '0;
    f[FB-1 -: 24] = v.hdr;
    for (int k = 1; k <= 8; k++) begin
      if (k == 2)      ch = v.c2;
      else if (k == 8) ch = v.c8;
      else             ch = {6{4'(k + 8)}};
      f[FB-1-24*k -: 24] = ch;
    end
    return f;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input int idx, input bit inj_ovr, input bit drop_en, input bit exp_ovr);
    int n, m, inj_cyc, lows;
    bit injected, prev_cs;
    cur_frame = build_frame(vecs[idx]);
    step();
    bus_if.drdy_n = 1'b0;
    n = 0;
    do begin
      step();
      n++;
    end while (bus_if.cs_n && n < 10);
    chk("cs_n_fall_latency", n, 4);
    bus_if.drdy_n = 1'b1;
    if (bus_if.cs_n) return;
    m = 0; inj_cyc = 0; injected = 1'b0; prev_cs = bus_if.cs_n;
    while (!(bus_if.valid || bus_if.frame_err) && m < 2000) begin
      prev_cs = bus_if.cs_n;
      step();
      m++;
      if (inj_ovr && !injected && rises == 100) begin
        bus_if.drdy_n = 1'b0;
        injected = 1'b1;
      end
      if (injected) begin
        inj_cyc++;
        if (inj_cyc == 6) bus_if.drdy_n = 1'b1;
      end
      if (drop_en && rises == 50) en = 1'b0;
    end
    chk("pulse_latency", m, 1729);
    chk("cs_n_low_before_pulse", 32'(prev_cs), 0);
    chk("cs_n_at_pulse", 32'(bus_if.cs_n), 1);
    chk("valid", 32'(bus_if.valid), 32'(vecs[idx].exp_valid));
    chk("frame_err", 32'(bus_if.frame_err), 32'(!vecs[idx].exp_valid));
    chk("Sn0", 32'(bus_if.Sn0), 32'(vecs[idx].exp_sn));
    chk("Rn0", 32'(bus_if.Rn0), 32'(vecs[idx].exp_rn));
    chk("status", 32'(bus_if.status), 32'(vecs[idx].exp_st));
    chk("sclk_rises", rises, 216);
    chk("ovr", 32'(bus_if.ovr), 32'(exp_ovr));
    $display("frame %0d hdr=%h valid=%b frame_err=%b Sn0=%h Rn0=%h status=%h ovr=%b",
             idx, vecs[idx].hdr, bus_if.valid, bus_if.frame_err,
             bus_if.Sn0, bus_if.Rn0, bus_if.status, bus_if.ovr);
    step();
    chk("pulse_one_cycle", 32'({bus_if.valid, bus_if.frame_err}), 0);
    lows = 0;
    repeat (20) begin
      step();
      if (!bus_if.cs_n) lows++;
    end
    chk("no_restart", lows, 0);
  endtask

  initial begin
    int lows, r0, n;
    vecs[0] = '{24'hC00000, 24'h123456, 24'hFEDCBA, 1'b1, 24'h123456, 24'hFEDCBA, 24'hC00000};
    vecs[1] = '{24'hA00000, 24'h111111, 24'h222222, 1'b0, 24'h123456, 24'hFEDCBA, 24'hC00000};
    vecs[2] = '{24'hCFFFFF, 24'h800000, 24'h7FFFFF, 1'b1, 24'h800000, 24'h7FFFFF, 24'hCFFFFF};
    vecs[3] = '{24'h300000, 24'h999999, 24'h888888, 1'b0, 24'h800000, 24'h7FFFFF, 24'hCFFFFF};
    vecs[4] = '{24'hC5A5A5, 24'h000001, 24'hFFFFFF, 1'b1, 24'h000001, 24'hFFFFFF, 24'hC5A5A5};
    vecs[5] = '{24'hD00000, 24'hABCDEF, 24'h012345, 1'b0, 24'h000001, 24'hFFFFFF, 24'hC5A5A5};
    vecs[6] = '{24'hB00000, 24'h555555, 24'h666666, 1'b0, 24'h000001, 24'hFFFFFF, 24'hC5A5A5};

    // Reset with DRDY held low: nothing may start.
    bus_if.drdy_n = 1'b0;
    bus_if.dout   = 1'b0;
    reset = 1'b1;
    repeat (3) step();
    chk("rst_cs_n", 32'(bus_if.cs_n), 1);
    chk("rst_sclk", 32'(bus_if.sclk), 0);
    chk("rst_Sn0", 32'(bus_if.Sn0), 0);
    chk("rst_Rn0", 32'(bus_if.Rn0), 0);
    chk("rst_status", 32'(bus_if.status), 0);
    chk("rst_flags", 32'({bus_if.valid, bus_if.frame_err, bus_if.ovr}), 0);
    reset = 1'b0;
    lows = 0;
    repeat (20) begin
      step();
      if (!bus_if.cs_n) lows++;
    end
    chk("no_start_after_reset", lows, 0);
    chk("no_sclk_after_reset", total_rises, 0);
    $display("reset check done");
    bus_if.drdy_n = 1'b1;
    repeat (10) step();

    for (int i = 0; i < 7; i++) run_frame(i, 1'b0, 1'b0, 1'b0);

    // en low: DRDY toggling must not start frames.
    en = 1'b0;
    lows = 0;
    r0 = total_rises;
    repeat (4) begin
      bus_if.drdy_n = 1'b0;
      repeat (10) begin step(); if (!bus_if.cs_n) lows++; end
      bus_if.drdy_n = 1'b1;
      repeat (10) begin step(); if (!bus_if.cs_n) lows++; end
    end
    chk("en0_cs_n_idle", lows, 0);
    chk("en0_no_sclk", total_rises - r0, 0);
    $display("en=0 idle check done");
    en = 1'b1;

    // en dropped mid-frame: frame still completes.
    run_frame(4, 1'b0, 1'b1, 1'b0);
    en = 1'b1;
    repeat (5) step();

    // Reset at bit 100.
    cur_frame = build_frame(vecs[0]);
    step();
    bus_if.drdy_n = 1'b0;
    n = 0;
    do begin step(); n++; end while (bus_if.cs_n && n < 10);
    bus_if.drdy_n = 1'b1;
    n = 0;
    while (rises < 100 && n < 1000) begin step(); n++; end
    chk("midrst_reached_bit100", 32'(rises >= 100), 1);
    reset = 1'b1;
    step();
    chk("midrst_cs_n", 32'(bus_if.cs_n), 1);
    chk("midrst_sclk", 32'(bus_if.sclk), 0);
    chk("midrst_Sn0_cleared", 32'(bus_if.Sn0), 0);
    reset = 1'b0;
    lows = 0;
    repeat (1800) begin
      step();
      if (bus_if.valid || bus_if.frame_err || !bus_if.cs_n) lows++;
    end
    chk("midrst_no_pulse", lows, 0);
    $display("reset mid-frame done");
    run_frame(0, 1'b0, 1'b0, 1'b0);

    // Overrun: second DRDY at bit 100.
    run_frame(2, 1'b1, 1'b0, 1'b1);
    repeat (50) step();
    chk("ovr_sticky", 32'(bus_if.ovr), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    chk("ovr_cleared_by_reset", 32'(bus_if.ovr), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
